// File: rtl/rs_sel_pkg.sv
// Shared types for the reservation-station issue selector.
//   RS_N      : number of RS entries (from `RS_SIZE, default 32)
//   RS_IDX_W  : width of an RS entry index
//   rs_oh_t   : one-hot / bit-vector over all RS entries
//   rs_idx_t  : binary RS entry index
`ifndef RS_SIZE
`define RS_SIZE 32
`endif

package rs_sel_pkg;
  localparam int RS_N     = `RS_SIZE;
  localparam int RS_IDX_W = $clog2(`RS_SIZE);

  typedef logic [`RS_SIZE-1:0] rs_oh_t;
  typedef logic [RS_IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/rs_rr_issue_select_prio_enc.sv
// rr_prio_enc: combinational rotating priority encoder.
// Scans i_req starting at i_start, upward with wrap, and returns the first set bit.
// Ports:
//   i_req   [N]      request vector
//   i_start [PTR_W]  index searched first
//   o_gnt   [N]      one-hot of the winning bit (zero when none)
//   o_idx   [PTR_W]  binary index of the winning bit (zero when none)
//   o_any            at least one request present
module rr_prio_enc
  import rs_sel_pkg::*;
#(
  parameter int N = RS_N,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_start,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  logic [PTR_W-1:0] w_pos;

  // N is a power of two, so PTR_W-bit addition wraps N-1 -> 0 for free.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = i_start + PTR_W'(k);
      if (!o_any && i_req[w_pos]) begin
        o_any = 1'b1;
        o_idx = w_pos;
      end
    end
    o_gnt[o_idx] = o_any;
  end

endmodule

// File: rtl/rs_rr_issue_select.sv
// rs_rr_issue_select: round-robin issue selector for the reservation station.
// Picks one ready RS entry and presents it as a registered one-hot grant that is
// held until the FU accepts it; the accepted one-hot is returned to free the slot.
// Optional feature macro: RS_SEL_PERF_EN (adds the stall_cnt output/counter).
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   squash     flush; drops any held grant
//   ready_vec  per-entry ready
//   fu_ready   FU accepts an issue this cycle
//   gnt_valid  gnt_oh holds a valid grant
//   gnt_oh     registered one-hot grant
//   fire_oh    grant accepted this cycle (RS clears these entries)
//   rr_ptr     current round-robin search start
//   stall_cnt  (RS_SEL_PERF_EN) cycles with gnt_valid & !fu_ready, saturating
//
// state | meaning
// IDLE  | no grant held, gnt_oh = 0
// HOLD  | grant valid, waiting for fu_ready
module rs_rr_issue_select
  import rs_sel_pkg::*;
#(
  parameter int N = RS_N,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic [N-1:0]     ready_vec,
  input  logic             fu_ready,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_oh,
  output logic [N-1:0]     fire_oh,
`ifdef RS_SEL_PERF_EN
  output logic [31:0]      stall_cnt,
`endif
  output logic [PTR_W-1:0] rr_ptr
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic [N-1:0]     r_gnt_oh;
  logic [PTR_W-1:0] r_gnt_idx;
  logic [PTR_W-1:0] r_rr_ptr;

  logic             w_fire;
  logic             w_load;
  logic [N-1:0]     w_cand;
  logic [N-1:0]     w_sel_oh;
  logic [PTR_W-1:0] w_sel_idx;
  logic             w_sel_any;

  assign gnt_valid = (r_state == ST_HOLD);
  assign gnt_oh    = r_gnt_oh;
  assign rr_ptr    = r_rr_ptr;

  assign w_fire  = gnt_valid & fu_ready;
  assign fire_oh = r_gnt_oh & {N{w_fire}};
  assign w_load  = !gnt_valid | w_fire;
  // The entry firing this cycle is still marked ready by the RS; mask it so the
  // next grant goes elsewhere and issue can sustain one per cycle.
  assign w_cand  = ready_vec & ~fire_oh;

  rr_prio_enc #(.N(N)) u_prio_enc (
    .i_req   (w_cand),
    .i_start (r_rr_ptr),
    .o_gnt   (w_sel_oh),
    .o_idx   (w_sel_idx),
    .o_any   (w_sel_any)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_gnt_oh  <= '0;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
    end else begin
      if (squash) begin
        r_state  <= ST_IDLE;
        r_gnt_oh <= '0;
      end else if (w_load) begin
        r_state   <= w_sel_any ? ST_HOLD : ST_IDLE;
        r_gnt_oh  <= w_sel_oh;
        r_gnt_idx <= w_sel_idx;
      end
      // A fire in a squash cycle was already accepted by the FU, so it still advances.
      if (w_fire) begin
        r_rr_ptr <= r_gnt_idx + PTR_W'(1);
      end
    end
  end

`ifdef RS_SEL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (gnt_valid && !fu_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rs_rr_issue_select.sv
module tb_rs_rr_issue_select;
  import rs_sel_pkg::*;

  logic       clock;
  logic       reset;
  logic       squash;
  rs_oh_t     ready_vec;
  logic       fu_ready;
  logic       gnt_valid;
  rs_oh_t     gnt_oh;
  rs_oh_t     fire_oh;
  logic [4:0] rr_ptr;
`ifdef RS_SEL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rs_rr_issue_select dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .ready_vec (ready_vec),
    .fu_ready  (fu_ready),
    .gnt_valid (gnt_valid),
    .gnt_oh    (gnt_oh),
    .fire_oh   (fire_oh),
`ifdef RS_SEL_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .rr_ptr    (rr_ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    rs_oh_t     ready;
    logic       fu;
    logic       sq;
    logic       ev;
    rs_oh_t     eg;
    rs_oh_t     ef;
    logic [4:0] ep;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side model of onehot_to_binary_RS.
  function automatic int oh2bin(input rs_oh_t oh);
    int r = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic inv();
    chk("onehot0", 32'($onehot0(gnt_oh)), 32'd1);
    chk("rs_contract", gnt_oh & ~ready_vec, 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input rs_oh_t r, input logic f, input logic s);
    ready_vec = r;
    fu_ready  = f;
    squash    = s;
    #1;
  endtask

  initial begin
    // ready, fu, squash | exp gnt_valid, gnt_oh, fire_oh, rr_ptr (before the edge)
    tbl[0]  = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0};
    tbl[1]  = '{32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0};
    tbl[2]  = '{32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 5'd0};
    tbl[3]  = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd5};
    tbl[4]  = '{32'h8000_0001, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd5};
    tbl[5]  = '{32'h8000_0001, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd5};
    tbl[6]  = '{32'h8000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 5'd0};
    tbl[7]  = '{32'h8000_0001, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd1};
    tbl[8]  = '{32'h8000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 5'd0};
    tbl[9]  = '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd1};
    tbl[10] = '{32'h4000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0};
    tbl[11] = '{32'h4000_0000, 1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000, 5'd0};
    tbl[12] = '{32'h0000_0006, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd31};
    tbl[13] = '{32'h0000_0006, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0002, 5'd31};
    tbl[14] = '{32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 5'd2};
    tbl[15] = '{32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004, 5'd2};
    tbl[16] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd3};

    reset = 1'b0;
    squash = 1'b0;
    ready_vec = '0;
    fu_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_gnt", gnt_oh, 32'd0);
    chk("rst_fire", fire_oh, 32'd0);
    chk("rst_ptr", 32'(rr_ptr), 32'd0);
`ifdef RS_SEL_PERF_EN
    chk("rst_stall", stall_cnt, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    step();

    // Table: single issue, fairness alternation, wrap past 31, brief hold.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].ready, tbl[i].fu, tbl[i].sq);
      chk($sformatf("tbl%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_gnt", i), gnt_oh, tbl[i].eg);
      chk($sformatf("tbl%0d_fire", i), fire_oh, tbl[i].ef);
      chk($sformatf("tbl%0d_ptr", i), 32'(rr_ptr), 32'(tbl[i].ep));
      inv();
      step();
    end

    // Hold/stall: grant 0x100 held across 4 stalled cycles while entry 0 becomes ready.
    drive(32'h0000_0100, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(32'h0000_0101, 1'b0, 1'b0);
      chk("hold_gnt", gnt_oh, 32'h0000_0100);
      chk("hold_fire", fire_oh, 32'd0);
      inv();
      step();
    end
    drive(32'h0000_0101, 1'b1, 1'b0);
    chk("hold_release_fire", fire_oh, 32'h0000_0100);
`ifdef RS_SEL_PERF_EN
    chk("stall_cnt4", stall_cnt, 32'd4);
`endif
    step();
    drive(32'h0000_0001, 1'b1, 1'b0);
    chk("after_hold_gnt", gnt_oh, 32'h0000_0001);
    chk("after_hold_ptr", 32'(rr_ptr), 32'd9);
    chk("after_hold_fire", fire_oh, 32'h0000_0001);
    step();
    drive(32'h0, 1'b1, 1'b0);
    chk("idle_ptr1", 32'(rr_ptr), 32'd1);
    chk("idle_valid", 32'(gnt_valid), 32'd0);

    // Squash without fire: grant dropped, pointer untouched.
    drive(32'h0000_0014, 1'b0, 1'b0);
    step();
    drive(32'h0000_0014, 1'b0, 1'b1);
    chk("sq_gnt_before", gnt_oh, 32'h0000_0004);
    chk("sq_bin_before", 32'(oh2bin(gnt_oh)), 32'd2);
    chk("sq_fire", fire_oh, 32'd0);
    step();
    drive(32'h0, 1'b0, 1'b0);
    chk("sq_valid", 32'(gnt_valid), 32'd0);
    chk("sq_gnt", gnt_oh, 32'd0);
    chk("sq_ptr", 32'(rr_ptr), 32'd1);

    // Squash in the same cycle as a fire: fire still seen, pointer still advances.
    drive(32'h0000_0014, 1'b0, 1'b0);
    step();
    drive(32'h0000_0014, 1'b1, 1'b1);
    chk("sqf_fire", fire_oh, 32'h0000_0004);
    step();
    drive(32'h0, 1'b0, 1'b0);
    chk("sqf_valid", 32'(gnt_valid), 32'd0);
    chk("sqf_ptr", 32'(rr_ptr), 32'd3);

    // Asynchronous reset in the middle of a hold.
    drive(32'h0000_0008, 1'b0, 1'b0);
    step();
    chk("pre_rst_gnt", gnt_oh, 32'h0000_0008);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(gnt_valid), 32'd0);
    chk("arst_gnt", gnt_oh, 32'd0);
    chk("arst_ptr", 32'(rr_ptr), 32'd0);
`ifdef RS_SEL_PERF_EN
    chk("arst_stall", stall_cnt, 32'd0);
`endif
    ready_vec = '0;
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("post_rst_valid", 32'(gnt_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
